// File: rtl/sram_async_ctl.sv
// Request/done controller for one or two 16-bit asynchronous SRAMs that share
// address and OE/WE strobes; every pad-facing output comes straight from a flop.
module sram_async_ctl #(
  parameter int AW      = 18,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int TURN    = 1,
  parameter int DUAL    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   data_in,
  output logic [15:0]   data_out,
  input  logic          rd,
  input  logic          wr,
  input  logic          wr_inhibit,
  input  logic          byte_op,
  output logic          done,
  output logic          busy,
  output logic [AW-2:0] ram_a,
  output logic          ram_oe_n,
  output logic          ram_we_n,
  inout  wire  [15:0]   ram1_io,
  inout  wire  [15:0]   ram2_io,
  output logic          ram1_ce_n,
  output logic          ram1_ub_n,
  output logic          ram1_lb_n,
  output logic          ram2_ce_n,
  output logic          ram2_ub_n,
  output logic          ram2_lb_n
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RDONE, S_WR, S_WHOLD, S_TURN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Request capture: the caller may drop addr/data right after the accept edge.
  logic [AW-2:0]   a_q, a_d;
  logic            bank_q, bank_d;
  logic            ub_q, ub_d, lb_q, lb_d;
  logic            hi_q, hi_d;
  logic            byte_q, byte_d;
  logic            inh_q, inh_d;
  logic [15:0]     wdata_q, wdata_d;

  logic [15:0]     rdata_q, rdata_d;
  logic            oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic            ce1_n_q, ce1_n_d, ub1_n_q, ub1_n_d, lb1_n_q, lb1_n_d;
  logic            ce2_n_q, ce2_n_d, ub2_n_q, ub2_n_d, lb2_n_q, lb2_n_d;
  logic            drv1_q, drv1_d, drv2_q, drv2_d;
  logic            done_q, done_d;
  logic [15:0]     io_sel;

  assign io_sel = bank_q ? ram2_io : ram1_io;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ce1_n_q <= 1'b1;
      ub1_n_q <= 1'b1;
      lb1_n_q <= 1'b1;
      ce2_n_q <= 1'b1;
      ub2_n_q <= 1'b1;
      lb2_n_q <= 1'b1;
      drv1_q  <= 1'b0;
      drv2_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ce1_n_q <= ce1_n_d;
      ub1_n_q <= ub1_n_d;
      lb1_n_q <= lb1_n_d;
      ce2_n_q <= ce2_n_d;
      ub2_n_q <= ub2_n_d;
      lb2_n_q <= lb2_n_d;
      drv1_q  <= drv1_d;
      drv2_q  <= drv2_d;
      done_q  <= done_d;
    end
    a_q     <= a_d;
    bank_q  <= bank_d;
    ub_q    <= ub_d;
    lb_q    <= lb_d;
    hi_q    <= hi_d;
    byte_q  <= byte_d;
    inh_q   <= inh_d;
    wdata_q <= wdata_d;
  end

  // Next-state and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    bank_d  = bank_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    hi_d    = hi_q;
    byte_d  = byte_q;
    inh_d   = inh_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          a_d = addr[AW-1:1];
          if (DUAL != 0) a_d[AW-2] = 1'b0;
          bank_d  = (DUAL != 0) && addr[AW-1];
          byte_d  = byte_op;
          hi_d    = addr[0];
          ub_d    = !byte_op || addr[0];
          lb_d    = !byte_op || !addr[0];
          inh_d   = wr_inhibit;
          wdata_d = byte_op ? {2{data_in[7:0]}} : data_in;
          cnt_d   = '0;
          state_d = rd ? S_RD : S_WR;
        end
      end
      S_RD: begin
        if (cnt_q == CW'(RD_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_RDONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RDONE: state_d = S_IDLE;
      S_WR: begin
        if (cnt_q == CW'(WR_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WHOLD: begin
        cnt_d   = '0;
        state_d = (TURN > 0) ? S_TURN : S_IDLE;
      end
      S_TURN: begin
        if (cnt_q == CW'(TURN - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins change on the same edge as the state.
  always_comb begin
    ce1_n_d = 1'b1;
    ub1_n_d = 1'b1;
    lb1_n_d = 1'b1;
    ce2_n_d = 1'b1;
    ub2_n_d = 1'b1;
    lb2_n_d = 1'b1;
    drv1_d  = 1'b0;
    drv2_d  = 1'b0;
    rdata_d = rdata_q;
    oe_n_d  = (state_d != S_RD);
    we_n_d  = !((state_d == S_WR) && !inh_d);
    done_d  = (state_d == S_RDONE) || (state_d == S_WHOLD);
    if (state_d inside {S_RD, S_WR, S_WHOLD}) begin
      if (bank_d) begin
        ce2_n_d = 1'b0;
        ub2_n_d = !ub_d;
        lb2_n_d = !lb_d;
        drv2_d  = (state_d != S_RD);
      end else begin
        ce1_n_d = 1'b0;
        ub1_n_d = !ub_d;
        lb1_n_d = !lb_d;
        drv1_d  = (state_d != S_RD);
      end
    end
    if ((state_q == S_RD) && (state_d == S_RDONE))
      rdata_d = byte_q ? {8'h00, (hi_q ? io_sel[15:8] : io_sel[7:0])} : io_sel;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign data_out  = rdata_q;
  assign ram_a     = a_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram1_ce_n = ce1_n_q;
  assign ram1_ub_n = ub1_n_q;
  assign ram1_lb_n = lb1_n_q;
  assign ram2_ce_n = ce2_n_q;
  assign ram2_ub_n = ub2_n_q;
  assign ram2_lb_n = lb2_n_q;
  assign ram1_io   = drv1_q ? wdata_q : 16'hzzzz;
  assign ram2_io   = drv2_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_async_ctl.sv
// Directed bench for sram_async_ctl: table of single transactions against two
// behavioural SRAM models, plus hand sequences for collisions, busy and reset.
module tb_sram_async_ctl;
  localparam int AW      = 18;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int TURN    = 2;
  localparam int DUAL    = 1;
  localparam logic [15:0] PROBE = 16'h00FF;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [15:0]   data_in;
  logic [15:0]   data_out;
  logic          rd, wr, wr_inhibit, byte_op;
  logic          done, busy;
  logic [AW-2:0] ram_a;
  logic          ram_oe_n, ram_we_n;
  wire  [15:0]   ram1_io, ram2_io;
  logic          ram1_ce_n, ram1_ub_n, ram1_lb_n;
  logic          ram2_ce_n, ram2_ub_n, ram2_lb_n;

  logic [15:0]   mem1 [0:255];
  logic [15:0]   mem2 [0:255];
  logic          probe1_en = 1'b0;
  logic          probe2_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_async_ctl #(
    .AW(AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN), .DUAL(DUAL)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out),
    .rd(rd), .wr(wr), .wr_inhibit(wr_inhibit), .byte_op(byte_op),
    .done(done), .busy(busy), .ram_a(ram_a),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram1_io(ram1_io), .ram2_io(ram2_io),
    .ram1_ce_n(ram1_ce_n), .ram1_ub_n(ram1_ub_n), .ram1_lb_n(ram1_lb_n),
    .ram2_ce_n(ram2_ce_n), .ram2_ub_n(ram2_ub_n), .ram2_lb_n(ram2_lb_n)
  );

  // SRAM models: drive on CE&OE with WE high; a probe pattern tests for a floating bus.
  assign ram1_io = (!ram1_ce_n && !ram_oe_n && ram_we_n) ? mem1[ram_a[7:0]] :
                   (probe1_en ? PROBE : 16'hzzzz);
  assign ram2_io = (!ram2_ce_n && !ram_oe_n && ram_we_n) ? mem2[ram_a[7:0]] :
                   (probe2_en ? PROBE : 16'hzzzz);

  always @(posedge ram_we_n) begin
    if (!ram1_ce_n) begin
      if (!ram1_ub_n) mem1[ram_a[7:0]][15:8] = ram1_io[15:8];
      if (!ram1_lb_n) mem1[ram_a[7:0]][7:0]  = ram1_io[7:0];
    end
    if (!ram2_ce_n) begin
      if (!ram2_ub_n) mem2[ram_a[7:0]][15:8] = ram2_io[15:8];
      if (!ram2_lb_n) mem2[ram_a[7:0]][7:0]  = ram2_io[7:0];
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h want %04h", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h want %05h", nm, act, exp);
    end
  endtask

  // The probe pattern reads back unchanged only if the DUT leaves that bus floating.
  task automatic probe_chk(input logic bank, input string nm);
    if (bank) probe2_en = 1'b1; else probe1_en = 1'b1;
    #1;
    chk16(nm, bank ? ram2_io : ram1_io, PROBE);
    probe1_en = 1'b0;
    probe2_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_wr;
    logic        bop;
    logic        inh;
    logic [17:0] a;
    logic [15:0] din;
    logic [15:0] pre;
    logic [15:0] exp_do;
    logic [15:0] exp_io;
    logic [15:0] exp_mem;
    logic [16:0] exp_a;
    logic        bank;
    logic        ub_n;
    logic        lb_n;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int i, input vec_t v);
    logic sce, uce, sub, slb;
    logic [15:0] sio, mword;
    if (v.bank) mem2[v.exp_a[7:0]] = v.pre; else mem1[v.exp_a[7:0]] = v.pre;
    @(negedge clk);
    rd = !v.is_wr; wr = v.is_wr; addr = v.a; data_in = v.din;
    byte_op = v.bop; wr_inhibit = v.inh;
    step();
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = 16'h0000; byte_op = 1'b0; wr_inhibit = 1'b0;
    for (int k = 0; k <= (v.is_wr ? WR_WAIT + TURN + 1 : RD_WAIT + 1); k++) begin
      if (k > 0) step();
      sce = v.bank ? ram2_ce_n : ram1_ce_n;
      uce = v.bank ? ram1_ce_n : ram2_ce_n;
      sub = v.bank ? ram2_ub_n : ram1_ub_n;
      slb = v.bank ? ram2_lb_n : ram1_lb_n;
      sio = v.bank ? ram2_io : ram1_io;
      if (!v.is_wr) begin
        if (k < RD_WAIT) begin
          chk1($sformatf("v%0d k%0d oe_n", i, k), ram_oe_n, 1'b0);
          chk1($sformatf("v%0d k%0d we_n", i, k), ram_we_n, 1'b1);
          chk1($sformatf("v%0d k%0d ce_sel", i, k), sce, 1'b0);
          chk1($sformatf("v%0d k%0d ce_unsel", i, k), uce, 1'b1);
          chk1($sformatf("v%0d k%0d ub_n", i, k), sub, v.ub_n);
          chk1($sformatf("v%0d k%0d lb_n", i, k), slb, v.lb_n);
          chka($sformatf("v%0d k%0d ram_a", i, k), ram_a, v.exp_a);
          chk1($sformatf("v%0d k%0d done", i, k), done, 1'b0);
          chk1($sformatf("v%0d k%0d busy", i, k), busy, 1'b1);
          if (k == 0) probe_chk(!v.bank, $sformatf("v%0d unsel io float", i));
        end else if (k == RD_WAIT) begin
          chk1($sformatf("v%0d k%0d oe_n", i, k), ram_oe_n, 1'b1);
          chk1($sformatf("v%0d k%0d ce_sel", i, k), sce, 1'b1);
          chk1($sformatf("v%0d k%0d done", i, k), done, 1'b1);
          chk16($sformatf("v%0d data_out", i), data_out, v.exp_do);
        end else begin
          chk1($sformatf("v%0d k%0d done", i, k), done, 1'b0);
          chk1($sformatf("v%0d k%0d busy", i, k), busy, 1'b0);
        end
      end else begin
        if (k < WR_WAIT) begin
          chk1($sformatf("v%0d k%0d we_n", i, k), ram_we_n, v.inh);
          chk1($sformatf("v%0d k%0d oe_n", i, k), ram_oe_n, 1'b1);
          chk1($sformatf("v%0d k%0d ce_sel", i, k), sce, 1'b0);
          chk1($sformatf("v%0d k%0d ce_unsel", i, k), uce, 1'b1);
          chk1($sformatf("v%0d k%0d ub_n", i, k), sub, v.ub_n);
          chk1($sformatf("v%0d k%0d lb_n", i, k), slb, v.lb_n);
          chka($sformatf("v%0d k%0d ram_a", i, k), ram_a, v.exp_a);
          chk16($sformatf("v%0d k%0d io", i, k), sio, v.exp_io);
          chk1($sformatf("v%0d k%0d done", i, k), done, 1'b0);
          if (k == 0) probe_chk(!v.bank, $sformatf("v%0d unsel io float", i));
        end else if (k == WR_WAIT) begin
          chk1($sformatf("v%0d whold we_n", i), ram_we_n, 1'b1);
          chk1($sformatf("v%0d whold oe_n", i), ram_oe_n, 1'b1);
          chk1($sformatf("v%0d whold ce_sel", i), sce, 1'b0);
          chk16($sformatf("v%0d whold io", i), sio, v.exp_io);
          chk1($sformatf("v%0d whold done", i), done, 1'b1);
        end else if (k <= WR_WAIT + TURN) begin
          chk1($sformatf("v%0d turn k%0d busy", i, k), busy, 1'b1);
          chk1($sformatf("v%0d turn k%0d done", i, k), done, 1'b0);
          chk1($sformatf("v%0d turn k%0d ce_sel", i, k), sce, 1'b1);
          if (k == WR_WAIT + 1) probe_chk(v.bank, $sformatf("v%0d turn io float", i));
        end else begin
          chk1($sformatf("v%0d end busy", i), busy, 1'b0);
        end
      end
    end
    mword = v.bank ? mem2[v.exp_a[7:0]] : mem1[v.exp_a[7:0]];
    chk16($sformatf("v%0d mem", i), mword, v.exp_mem);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           wr    byte  inh   addr        din       pre       exp_do    exp_io    exp_mem   exp_a       bank  ub_n  lb_n
    vecs[0] = '{1'b0, 1'b0, 1'b0, 18'h00100, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 16'hBEEF, 17'h00080, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 18'h00003, 16'h1234, 16'hABCD, 16'h0000, 16'h3434, 16'h34CD, 17'h00001, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 18'h20004, 16'h0000, 16'hCAFE, 16'hCAFE, 16'h0000, 16'hCAFE, 17'h00002, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 18'h20005, 16'h0000, 16'hCAFE, 16'h00CA, 16'h0000, 16'hCAFE, 17'h00002, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 18'h00102, 16'h0000, 16'h5A69, 16'h0069, 16'h0000, 16'h5A69, 17'h00081, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 18'h20010, 16'h1357, 16'h0000, 16'h0000, 16'h1357, 16'h1357, 17'h00008, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 18'h00006, 16'h7E81, 16'h1111, 16'h0000, 16'h7E81, 16'h1111, 17'h00003, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 18'h20008, 16'h00A7, 16'h5555, 16'h0000, 16'hA7A7, 16'h55A7, 17'h00004, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 18'h00101, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 16'hBEEF, 17'h00080, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = 16'h0000;
    byte_op = 1'b0; wr_inhibit = 1'b0;
    repeat (3) step();
    chk1("rst oe_n", ram_oe_n, 1'b1);
    chk1("rst we_n", ram_we_n, 1'b1);
    chk1("rst ce1_n", ram1_ce_n, 1'b1);
    chk1("rst ub1_n", ram1_ub_n, 1'b1);
    chk1("rst lb1_n", ram1_lb_n, 1'b1);
    chk1("rst ce2_n", ram2_ce_n, 1'b1);
    chk1("rst ub2_n", ram2_ub_n, 1'b1);
    chk1("rst lb2_n", ram2_lb_n, 1'b1);
    chk1("rst done", done, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk16("rst data_out", data_out, 16'h0000);
    probe_chk(1'b0, "rst io1 float");
    probe_chk(1'b1, "rst io2 float");
    reset = 1'b0;
    for (int j = 0; j < 256; j++) begin
      mem1[j] = 16'h0000;
      mem2[j] = 16'h0000;
    end
    step();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // rd and wr together: the read wins and memory is untouched.
    mem1[8'h80] = 16'h4321;
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 18'h00100; data_in = 16'h0000;
    step();
    rd = 1'b0; wr = 1'b0;
    chk1("rdwr oe_n", ram_oe_n, 1'b0);
    chk1("rdwr we_n", ram_we_n, 1'b1);
    repeat (RD_WAIT) step();
    chk1("rdwr done", done, 1'b1);
    chk16("rdwr data_out", data_out, 16'h4321);
    step();
    chk16("rdwr mem", mem1[8'h80], 16'h4321);

    // wr held high with a new address while busy: only the first request runs.
    mem1[8'h10] = 16'h0000;
    mem1[8'h11] = 16'h9999;
    @(negedge clk);
    wr = 1'b1; addr = 18'h00020; data_in = 16'h2468;
    step();
    addr = 18'h00022; data_in = 16'h1111;
    for (int k = 0; k <= WR_WAIT + TURN; k++) begin
      if (k > 0) step();
      chk1($sformatf("hold k%0d busy", k), busy, 1'b1);
      chk1($sformatf("hold k%0d done", k), done, (k == WR_WAIT) ? 1'b1 : 1'b0);
    end
    wr = 1'b0;
    step();
    chk1("hold end busy", busy, 1'b0);
    chk16("hold mem first", mem1[8'h10], 16'h2468);
    chk16("hold mem ignored", mem1[8'h11], 16'h9999);
    chk16("hold data_out kept", data_out, 16'h4321);

    // Reset in the middle of a write aborts it with no done pulse.
    @(negedge clk);
    wr = 1'b1; addr = 18'h00014; data_in = 16'h7777;
    step();
    wr = 1'b0;
    chk1("abort pre we_n", ram_we_n, 1'b0);
    reset = 1'b1;
    step();
    chk1("abort we_n", ram_we_n, 1'b1);
    chk1("abort oe_n", ram_oe_n, 1'b1);
    chk1("abort ce1_n", ram1_ce_n, 1'b1);
    chk1("abort ub1_n", ram1_ub_n, 1'b1);
    chk1("abort lb1_n", ram1_lb_n, 1'b1);
    chk1("abort ce2_n", ram2_ce_n, 1'b1);
    chk1("abort done", done, 1'b0);
    chk1("abort busy", busy, 1'b0);
    probe_chk(1'b0, "abort io1 float");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1($sformatf("post abort k%0d done", k), done, 1'b0);
      chk1($sformatf("post abort k%0d busy", k), busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
